// File: rtl/riscv_unified_mem_arbiter.sv
// rtl/riscv_unified_mem_arbiter.sv - fetch/data arbiter in front of one single-port synchronous-read word RAM
module riscv_unified_mem_arbiter #(
    parameter int          MEM_WORDS    = 2048,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          STARVE_LIMIT = 4,
    localparam int         ADDR_W       = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_valid,
    output logic [31:0]       i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              err,
    output logic              err_sticky
);
    localparam int          CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [32:0] SPAN  = 33'(MEM_WORDS) << 2;

    typedef enum logic [2:0] {
        RSP_NONE,
        RSP_I,
        RSP_D,
        RSP_BAD_I,
        RSP_BAD_D
    } rsp_t;

    rsp_t             state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    logic             want_d;
    logic [31:0]      acc_addr;
    logic [32:0]      offset;
    logic             acc_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RSP_NONE;
            starve_cnt <= '0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if (err) begin
                err_sticky <= 1'b1;
            end
        end
    end

    // Grants are gated by rst so every output reads 0 while reset is held.
    always_comb begin
        want_d = d_read | d_write;
        i_gnt  = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if (i_req && (starve_cnt == CNT_W'(STARVE_LIMIT))) begin
                i_gnt = 1'b1;
            end else if (want_d) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end

        acc_addr = d_gnt ? d_addr : i_addr;
        // A borrow out of the 33-bit subtraction means the address is below BASE_ADDR.
        offset   = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
        acc_ok   = !offset[32] && (offset < SPAN) && (acc_addr[1:0] == 2'b00);

        mem_en    = (i_gnt | d_gnt) & acc_ok;
        mem_we    = mem_en & d_gnt & d_write;
        mem_addr  = mem_en ? offset[ADDR_W+1:2] : '0;
        mem_wdata = mem_we ? d_wdata : '0;

        err   = ((i_gnt | d_gnt) & ~acc_ok) | (d_gnt & d_read & d_write);
        stall = ~rst & ((i_req & ~i_gnt) | (want_d & ~d_gnt));

        state_nxt = RSP_NONE;
        if (i_gnt) begin
            state_nxt = acc_ok ? RSP_I : RSP_BAD_I;
        end else if (d_gnt && !d_write) begin
            state_nxt = acc_ok ? RSP_D : RSP_BAD_D;
        end

        starve_nxt = '0;
        if (i_req && !i_gnt) begin
            starve_nxt = (starve_cnt == CNT_W'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
        end
    end

    // Bad-address reads still answer, but with a zero word.
    always_comb begin
        i_valid = (state == RSP_I) || (state == RSP_BAD_I);
        d_valid = (state == RSP_D) || (state == RSP_BAD_D);
        i_rdata = (state == RSP_I) ? mem_rdata : 32'h0;
        d_rdata = (state == RSP_D) ? mem_rdata : 32'h0;
    end
endmodule

// File: tb/tb_riscv_unified_mem_arbiter.sv
// tb/tb_riscv_unified_mem_arbiter.sv - scoreboard bench for riscv_unified_mem_arbiter
module tb_riscv_unified_mem_arbiter;
    localparam int          MEM_WORDS    = 2048;
    localparam logic [31:0] BASE_ADDR    = 32'h0000_0000;
    localparam int          STARVE_LIMIT = 4;
    localparam int          AW           = $clog2(MEM_WORDS);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [31:0]   i_addr = '0, d_addr = '0, d_wdata = '0;
    logic          i_gnt, i_valid, d_gnt, d_valid, stall, mem_en, mem_we, err, err_sticky;
    logic [31:0]   i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;

    riscv_unified_mem_arbiter #(
        .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 4) return 32'h0010_0073;
        return {idx[15:0], ~idx[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // External RAM: single port, read data registered one cycle after the access.
    logic [31:0] ram [MEM_WORDS];
    bit ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int k = 0; k < MEM_WORDS; k++) ram[k] <= init_word(k);
            ram_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents by word, expected responses per requester.
    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic [31:0] model_mem [int];
    exp_t        iq [$];
    exp_t        dq [$];
    int          cyc = 0;
    int          starve = 0;
    bit          sticky_exp = 1'b0;

    function automatic bit addr_good(input logic [31:0] a);
        longint la = longint'(a);
        longint lo = longint'(BASE_ADDR);
        return (a % 4 == 0) && (la >= lo) && (la < lo + longint'(MEM_WORDS) * 4);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE_ADDR)) / 4);
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        if (model_mem.exists(idx)) return model_mem[idx];
        return init_word(idx);
    endfunction

    always @(negedge clk) begin
        bit          want_i, want_d, eg_i, eg_d, ok, e_err, e_en, e_we;
        logic [31:0] a;
        exp_t        e;
        if (rst) begin
            iq.delete();
            dq.delete();
            starve     = 0;
            sticky_exp = 1'b0;
        end else if (mon_on) begin
            want_i = i_req;
            want_d = d_read | d_write;
            eg_i   = want_i && (starve == STARVE_LIMIT || !want_d);
            eg_d   = want_d && !eg_i;
            chk("i_gnt", i_gnt, eg_i);
            chk("d_gnt", d_gnt, eg_d);
            chk("stall", stall, (want_i && !eg_i) || (want_d && !eg_d));

            if (iq.size() > 0 && iq[0].cyc == cyc) begin
                e = iq.pop_front();
                chk("i_valid", i_valid, 1);
                chk("i_rdata", i_rdata, e.data);
            end else begin
                chk("i_valid_idle", i_valid, 0);
                chk("i_rdata_idle", i_rdata, 0);
            end
            if (dq.size() > 0 && dq[0].cyc == cyc) begin
                e = dq.pop_front();
                chk("d_valid", d_valid, 1);
                chk("d_rdata", d_rdata, e.data);
            end else begin
                chk("d_valid_idle", d_valid, 0);
                chk("d_rdata_idle", d_rdata, 0);
            end

            a     = eg_d ? d_addr : i_addr;
            ok    = addr_good(a);
            e_en  = (eg_i || eg_d) && ok;
            e_we  = e_en && eg_d && d_write;
            e_err = ((eg_i || eg_d) && !ok) || (eg_d && d_read && d_write);
            chk("err", err, e_err);
            chk("mem_en", mem_en, e_en);
            chk("mem_we", mem_we, e_we);
            if (e_en) chk("mem_addr", 32'(mem_addr), 32'(word_of(a)));
            if (e_we) chk("mem_wdata", mem_wdata, d_wdata);
            chk("err_sticky", err_sticky, sticky_exp);

            if (eg_d && d_write) begin
                if (ok) model_mem[word_of(a)] = d_wdata;
            end else if (eg_i || eg_d) begin
                e.cyc  = cyc + 1;
                e.data = ok ? model_read(word_of(a)) : 32'h0;
                if (eg_i) iq.push_back(e);
                else      dq.push_back(e);
            end

            if (want_i && !eg_i) starve = (starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT;
            else                 starve = 0;
            if (e_err) sticky_exp = 1'b1;
            cyc++;
        end
    end

    // Drivers start at posedge+1, hold the request until granted, and report the wait in cycles.
    task automatic do_fetch(input logic [31:0] a, output int w);
        i_req  = 1'b1;
        i_addr = a;
        w      = 0;
        do begin @(negedge clk); w++; end while (!i_gnt && w < 40);
        if (!i_gnt) begin
            n_cmp++; n_bad++;
            $display("FAIL fetch_timeout: no i_gnt after %0d cycles, required a grant", w);
        end
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic do_data(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, output int w);
        d_read  = rd;
        d_write = wr;
        d_addr  = a;
        d_wdata = wd;
        w       = 0;
        do begin @(negedge clk); w++; end while (!d_gnt && w < 40);
        if (!d_gnt) begin
            n_cmp++; n_bad++;
            $display("FAIL data_timeout: no d_gnt after %0d cycles, required a grant", w);
        end
        @(posedge clk); #1;
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 19);
        if (r == 0) return 32'($urandom_range(0, MEM_WORDS - 1) * 4 + $urandom_range(1, 3));
        if (r == 1) return 32'(MEM_WORDS * 4 + $urandom_range(0, 15) * 4);
        if (r < 12) return 32'($urandom_range(0, 31) * 4);
        return 32'($urandom_range(0, MEM_WORDS - 1) * 4);
    endfunction

    task automatic rand_fetch(input int n);
        int w;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            do_fetch(rand_addr(), w);
        end
    endtask

    task automatic rand_data(input int n);
        int w;
        int op;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            op = $urandom_range(0, 9);
            do_data(op < 5, op >= 5, rand_addr(), $urandom, w);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_i_gnt"}, i_gnt, 0);
        chk({tag, "_d_gnt"}, d_gnt, 0);
        chk({tag, "_i_valid"}, i_valid, 0);
        chk({tag, "_d_valid"}, d_valid, 0);
        chk({tag, "_i_rdata"}, i_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_sticky"}, err_sticky, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int wf, wd, w;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk); #1;

        do_fetch(32'h10, wf);
        chk("fetch_only_wait", wf, 1);

        fork
            do_fetch(32'h10, wf);
            do_data(1'b1, 1'b0, 32'h20, 32'h0, wd);
        join
        chk("contention_fetch_wait", wf, 2);
        chk("contention_data_wait", wd, 1);

        fork
            do_fetch(32'h14, wf);
            for (int k = 0; k < 7; k++) do_data(1'b1, 1'b0, 32'(k * 4), 32'h0, wd);
        join
        chk("starve_fetch_wait", wf, STARVE_LIMIT + 1);

        do_data(1'b0, 1'b1, 32'h1FFC, 32'hDEAD_BEEF, w);
        do_data(1'b1, 1'b0, 32'h1FFC, 32'h0, w);
        do_data(1'b0, 1'b1, 32'h1FFE, 32'h1111_1111, w);
        do_data(1'b1, 1'b0, 32'h2002, 32'h0, w);
        do_data(1'b1, 1'b0, 32'(MEM_WORDS * 4), 32'h0, w);
        do_data(1'b1, 1'b0, 32'h1FFC, 32'h0, w);
        do_fetch(32'h2001, w);
        do_data(1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, w);
        do_data(1'b1, 1'b0, 32'h40, 32'h0, w);
        @(negedge clk);
        chk("err_sticky_set", err_sticky, 1);
        @(posedge clk); #1;

        fork
            rand_fetch(200);
            rand_data(200);
        join

        i_req  = 1'b1;
        i_addr = 32'h10;
        @(posedge clk); #1;
        rst    = 1'b1;
        d_read = 1'b1;
        @(negedge clk);
        check_all_zero("in_reset");
        @(posedge clk); #1;
        rst    = 1'b0;
        i_req  = 1'b0;
        d_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("i_queue_drained", iq.size(), 0);
        chk("d_queue_drained", dq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
